noc_inject_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one router injection port among N_REQ flit sources
//  (fifo_router bridges, DMA engines). Grant locks from HEAD to TAIL so packets never interleave.

---
 rtl/noc_inject_arbiter_if.sv | 52 +++++
 rtl/noc_inject_arbiter.sv | 143 ++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_inject_arbiter_if.sv
// Shared flit types and the arbiter's requester/router handshake bundle.
// The master side drives requests and router flow control; the slave is the arbiter.
package noc_pkg;
    localparam int VC_NUM = 2;
    localparam int VC_SIZE = 1;
    localparam int TOTAL_PAYLOAD_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                   label;
        logic [VC_SIZE-1:0]            vc_id;
        logic [TOTAL_PAYLOAD_SIZE-1:0] data;
    } flit_t;
endpackage

interface noc_inject_arbiter_if #(
    parameter int N_REQ = 4
);
    import noc_pkg::*;

    logic [N_REQ-1:0]                    req_valid;
    logic [2*N_REQ-1:0]                  req_label;
    logic [N_REQ*TOTAL_PAYLOAD_SIZE-1:0] req_data;
    logic [N_REQ-1:0]                    req_ready;
    flit_t                               router_data_out;
    logic                                router_valid_out;
    logic [VC_NUM-1:0]                   router_is_on_off_in;
    logic [VC_NUM-1:0]                   router_is_allocatable_in;
    logic [$clog2(N_REQ)-1:0]            grant_id;
    logic                                busy;
    logic                                proto_err;

    modport master (
        output req_valid, req_label, req_data,
        output router_is_on_off_in, router_is_allocatable_in,
        input  req_ready, router_data_out, router_valid_out,
        input  grant_id, busy, proto_err
    );

    modport slave (
        input  req_valid, req_label, req_data,
        input  router_is_on_off_in, router_is_allocatable_in,
        output req_ready, router_data_out, router_valid_out,
        output grant_id, busy, proto_err
    );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter for one router injection port.
// Grant locks HEAD..TAIL; one idle cycle separates consecutive packets.
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int VC_OUT = 0
) (
    input logic              clk_router,
    input logic              rst_router,
    noc_inject_arbiter_if.slave inj
);
    localparam int GW = $clog2(N_REQ);
    localparam int P  = TOTAL_PAYLOAD_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    logic [GW-1:0] last_grant;
    logic        gap;

    flit_label_t lab [N_REQ];
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] stray;
    logic [N_REQ-1:0] ready;
    logic [GW-1:0] win;
    logic [GW-1:0] low;
    logic [GW-1:0] sel;
    logic        have_win;
    logic        have_stray;
    logic        on;
    logic        alloc;
    logic        accept;
    logic        fwd;
    logic        pkt_end;
    flit_label_t sel_lab;
    logic [P-1:0] sel_data;

    logic unused_vc;
    assign unused_vc = ^{inj.router_is_on_off_in, inj.router_is_allocatable_in};

    assign on    = inj.router_is_on_off_in[VC_OUT];
    assign alloc = inj.router_is_allocatable_in[VC_OUT];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lab[i]   = flit_label_t'(inj.req_label[2*i +: 2]);
            cand[i]  = inj.req_valid[i] && (lab[i] == HEAD || lab[i] == HEADTAIL);
            stray[i] = inj.req_valid[i] && (lab[i] == BODY || lab[i] == TAIL);
        end
    end

    // Rotating search starting just after the last packet's owner.
    always_comb begin
        have_win = 1'b0;
        win      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!have_win && cand[(int'(last_grant) + k) % N_REQ]) begin
                have_win = 1'b1;
                win      = GW'((int'(last_grant) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        have_stray = 1'b0;
        low        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (stray[i]) begin
                have_stray = 1'b1;
                low        = GW'(i);
            end
        end
    end

    always_comb begin
        ready = '0;
        sel   = win;
        if (rst_router) begin
            ready = '0;
        end else if (state == BUSY) begin
            sel             = grant_id_q();
            ready[sel]      = on;
        end else if (!gap && have_win) begin
            sel             = win;
            ready[win]      = on & alloc;
        end else if (!gap && have_stray) begin
            sel             = low;
            ready[low]      = 1'b1;
        end
    end

    function automatic logic [GW-1:0] grant_id_q();
        return inj.grant_id;
    endfunction

    assign inj.req_ready = ready;
    assign accept   = |(inj.req_valid & ready);
    assign sel_lab  = lab[sel];
    assign sel_data = inj.req_data[sel*P +: P];
    assign fwd      = accept && ((state == IDLE) ? have_win
                                 : (sel_lab == BODY || sel_lab == TAIL));
    assign pkt_end  = fwd && (sel_lab == HEADTAIL || sel_lab == TAIL);

    always_ff @(posedge clk_router or posedge rst_router) begin
        if (rst_router) begin
            state                 <= IDLE;
            last_grant            <= GW'(N_REQ - 1);
            gap                   <= 1'b0;
            inj.grant_id          <= '0;
            inj.busy              <= 1'b0;
            inj.proto_err         <= 1'b0;
            inj.router_valid_out  <= 1'b0;
            inj.router_data_out   <= '{label: HEADTAIL, vc_id: '0, data: '0};
        end else begin
            inj.proto_err        <= accept & ~fwd;
            inj.router_valid_out <= fwd;
            gap                  <= pkt_end;
            if (fwd) begin
                inj.router_data_out <= '{label: sel_lab,
                                         vc_id: VC_SIZE'(VC_OUT),
                                         data:  sel_data};
            end
            if (fwd && state == IDLE) begin
                inj.grant_id <= win;
                if (sel_lab == HEAD) begin
                    state    <= BUSY;
                    inj.busy <= 1'b1;
                end else begin
                    last_grant <= win;
                end
            end
            if (fwd && state == BUSY && sel_lab == TAIL) begin
                state      <= IDLE;
                inj.busy   <= 1'b0;
                last_grant <= inj.grant_id;
            end
        end
    end
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomized and directed bench for noc_inject_arbiter against a rule-level model.
// Packet generators per requester; every cycle compares ready and registered outputs.
module tb_noc_inject_arbiter;
    import noc_pkg::*;

    localparam int N  = 4;
    localparam int VC = 0;
    localparam int P  = TOTAL_PAYLOAD_SIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_inject_arbiter_if #(.N_REQ(N)) inj ();

    noc_inject_arbiter #(.N_REQ(N), .VC_OUT(VC)) dut (
        .clk_router (clk),
        .rst_router (rst),
        .inj        (inj)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester generators
    bit          has [N];
    int          rem [N];
    flit_label_t glab [N];
    logic [P-1:0] gdat [N];
    int          seq [N];
    bit          show [N];
    bit          stall_en = 0;
    bit          auto_start = 0;
    bit          ht_loop = 0;
    bit          rand_fc = 0;
    int          err_pct = 0;
    bit          r_on = 1;
    bit          r_alloc = 1;

    function automatic flit_label_t maybe_err(flit_label_t l);
        if (int'($urandom_range(99)) < err_pct) return flit_label_t'($urandom_range(3));
        return l;
    endfunction

    task automatic new_pkt(input int i, input int len);
        has[i]  = 1;
        rem[i]  = len;
        glab[i] = maybe_err((len == 1) ? HEADTAIL : HEAD);
        gdat[i] = {4'(i), 12'(seq[i])};
        seq[i]++;
    endtask

    task automatic advance(input int i);
        rem[i]--;
        if (rem[i] <= 0) begin
            has[i] = 0;
            if (ht_loop) new_pkt(i, 1);
        end else begin
            glab[i] = maybe_err((rem[i] == 1) ? TAIL : BODY);
            gdat[i] = {4'(i), 12'(seq[i])};
            seq[i]++;
        end
    endtask

    task automatic set_if();
        for (int i = 0; i < N; i++) begin
            inj.req_valid[i]        = has[i] && (show[i] || !stall_en);
            inj.req_label[2*i +: 2] = glab[i];
            inj.req_data[i*P +: P]  = gdat[i];
        end
        inj.router_is_on_off_in      = VC_NUM'($urandom);
        inj.router_is_allocatable_in = VC_NUM'($urandom);
        inj.router_is_on_off_in[VC]      = r_on;
        inj.router_is_allocatable_in[VC] = r_alloc;
    endtask

    // Model state
    int          m_owner = -1;
    int          m_last = N - 1;
    bit          m_gap = 0;
    bit          m_busy = 0;
    bit          m_err = 0;
    bit          m_vout = 0;
    int          m_gid = 0;
    flit_t       m_dout = '{label: HEADTAIL, vc_id: '0, data: '0};
    logic [N-1:0] m_acc = '0;
    flit_t       cap [$];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (m_acc[i]) advance(i);
            if (!has[i] && auto_start && $urandom_range(2) == 0)
                new_pkt(i, 1 + int'($urandom_range(3)));
            show[i] = ($urandom_range(3) != 0);
        end
        if (rand_fc) begin
            r_on    = ($urandom_range(9) < 8);
            r_alloc = ($urandom_range(9) < 8);
        end
        set_if();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 drive();
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_gap   = 0;
        m_busy  = 0;
        m_err   = 0;
        m_vout  = 0;
        m_gid   = 0;
        m_dout  = '{label: HEADTAIL, vc_id: '0, data: '0};
        m_acc   = '0;
    endtask

    function automatic bit is_head(flit_label_t l);
        return (l == HEAD || l == HEADTAIL);
    endfunction

    logic [N-1:0] er;
    int w, s, sel;
    bit acc, fw;
    flit_label_t sl;

    always @(negedge clk) begin
        if (rst) model_reset();
        check_eq("valid_out", inj.router_valid_out, m_vout);
        check_eq("data_out", inj.router_data_out, m_dout);
        check_eq("grant_id", inj.grant_id, m_gid);
        check_eq("busy", inj.busy, m_busy);
        check_eq("proto_err", inj.proto_err, m_err);
        if (inj.router_valid_out) cap.push_back(inj.router_data_out);

        er  = '0;
        sel = -1;
        if (!rst) begin
            if (m_owner >= 0) begin
                sel     = m_owner;
                er[sel] = inj.router_is_on_off_in[VC];
            end else if (!m_gap) begin
                w = -1;
                s = -1;
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (w < 0 && inj.req_valid[i] &&
                        is_head(flit_label_t'(inj.req_label[2*i +: 2]))) w = i;
                end
                for (int i = 0; i < N; i++)
                    if (s < 0 && inj.req_valid[i] &&
                        !is_head(flit_label_t'(inj.req_label[2*i +: 2]))) s = i;
                if (w >= 0) begin
                    sel     = w;
                    er[w]   = inj.router_is_on_off_in[VC] & inj.router_is_allocatable_in[VC];
                end else if (s >= 0) begin
                    sel   = s;
                    er[s] = 1'b1;
                end
            end
        end
        check_eq("req_ready", inj.req_ready, er);
        m_acc = er & inj.req_valid;

        if (!rst) begin
            acc = (sel >= 0) && m_acc[sel];
            sl  = (sel >= 0) ? flit_label_t'(inj.req_label[2*sel +: 2]) : HEAD;
            fw  = acc && ((m_owner < 0) == is_head(sl));
            m_err  = acc && !fw;
            m_vout = fw;
            m_gap  = 0;
            if (fw) begin
                m_dout.label = sl;
                m_dout.vc_id = VC_SIZE'(VC);
                m_dout.data  = inj.req_data[sel*P +: P];
                if (m_owner < 0) begin
                    m_gid = sel;
                    if (sl == HEAD) begin
                        m_owner = sel;
                        m_busy  = 1;
                    end else begin
                        m_last = sel;
                        m_gap  = 1;
                    end
                end else if (sl == TAIL) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_busy  = 0;
                    m_gap   = 1;
                end
            end
        end
    end

    task automatic clear_gens();
        for (int i = 0; i < N; i++) begin
            has[i] = 0;
            rem[i] = 0;
        end
        set_if();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 drive();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid", inj.router_valid_out, 1'b0);
        check_eq("rst_busy", inj.busy, 1'b0);
        check_eq("rst_gid", inj.grant_id, '0);
        check_eq("rst_err", inj.proto_err, 1'b0);
        check_eq("rst_ready", inj.req_ready, '0);
        check_eq("rst_label", inj.router_data_out.label, HEADTAIL);
        clear_gens();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int exp4 [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < N; i++) begin
            has[i] = 0; rem[i] = 0; seq[i] = 0; show[i] = 1;
            glab[i] = HEAD; gdat[i] = '0;
        end
        set_if();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two simultaneous 3-flit packets
        new_pkt(0, 3);
        new_pkt(2, 3);
        cap.delete();
        set_if();
        repeat (12) cycle();
        check_eq("t2_count", cap.size(), 6);
        if (cap.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check_eq("t2_src", cap[k].data[15:12], (k < 3) ? 0 : 2);
                check_eq("t2_vc", cap[k].vc_id, VC);
            end
            check_eq("t2_lab0", cap[0].label, HEAD);
            check_eq("t2_lab2", cap[2].label, TAIL);
        end

        // Flow-control stall mid-packet
        cap.delete();
        new_pkt(1, 4);
        set_if();
        cycle();
        cycle();
        r_on = 0;
        set_if();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("t3_ready", inj.req_ready, '0);
            if (k > 0) check_eq("t3_vout", inj.router_valid_out, 1'b0);
        end
        r_on = 1;
        set_if();
        repeat (8) cycle();
        check_eq("t3_count", cap.size(), 4);
        if (cap.size() == 4) begin
            check_eq("t3_l0", cap[0].label, HEAD);
            check_eq("t3_l1", cap[1].label, BODY);
            check_eq("t3_l2", cap[2].label, BODY);
            check_eq("t3_l3", cap[3].label, TAIL);
            for (int k = 1; k < 4; k++)
                check_eq("t3_seq", cap[k].data[11:0], cap[0].data[11:0] + 12'(k));
        end

        // Continuous HEADTAIL from everyone
        do_reset();
        ht_loop = 1;
        cap.delete();
        for (int i = 0; i < N; i++) new_pkt(i, 1);
        set_if();
        repeat (12) cycle();
        check_eq("t4_count", cap.size(), 6);
        if (cap.size() >= 6)
            for (int k = 0; k < 6; k++)
                check_eq("t4_order", cap[k].data[15:12], exp4[k]);
        ht_loop = 0;

        // Stray BODY in IDLE
        do_reset();
        cap.delete();
        has[3] = 1; rem[3] = 1; glab[3] = BODY; gdat[3] = 16'h3abc;
        set_if();
        #1 check_eq("t5_ready", inj.req_ready, 4'b1000);
        cycle();
        check_eq("t5_err", inj.proto_err, 1'b1);
        check_eq("t5_vout", inj.router_valid_out, 1'b0);
        cycle();
        check_eq("t5_err_end", inj.proto_err, 1'b0);
        check_eq("t5_cap", cap.size(), 0);

        // Allocation gating
        r_alloc = 0;
        new_pkt(0, 1);
        set_if();
        repeat (4) begin
            cycle();
            check_eq("t6_ready", inj.req_ready, '0);
        end
        r_alloc = 1;
        set_if();
        #1 check_eq("t6_ready_on", inj.req_ready, 4'b0001);
        cycle();
        check_eq("t6_vout", inj.router_valid_out, 1'b1);
        check_eq("t6_data", inj.router_data_out.data, {4'd0, 12'(seq[0] - 1)});
        repeat (3) cycle();

        // Random traffic with a mid-run reset
        stall_en   = 1;
        auto_start = 1;
        rand_fc    = 1;
        err_pct    = 5;
        repeat (1500) cycle();
        do_reset();
        repeat (1500) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
